// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encoding, sequential PC step and reset vector.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int          PC_STEP      = 4;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-entry fetch FSM driving the next-PC and instruction-memory request.
// Define IFETCH_DELAY_SLOT_EN for MIPS branch-delay-slot behaviour instead of flush-on-redirect.
module ifetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int PC_STEP = mips_pkg::PC_STEP
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] nPC,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target
);
    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_t      r_state;
    fetch_state_t      w_stateNext;
    logic [ADDR_W-1:0] r_inst;
    logic              r_instValid;
    logic [ADDR_W-1:0] r_imemAddr;
    logic [ADDR_W-1:0] w_nPC;
    logic [ADDR_W-1:0] w_pcInc;
    logic              w_addrLoad;
    logic [ADDR_W-1:0] w_addrNext;
    logic              w_instLoad;
    logic              w_validNext;

`ifdef IFETCH_DELAY_SLOT_EN
    logic              r_pendValid;
    logic [ADDR_W-1:0] r_pendTarget;
    logic              w_pendClr;
`endif

    assign w_pcInc = pc + STEP;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

`ifdef IFETCH_DELAY_SLOT_EN
    // Redirects never flush: the delay slot is delivered and its ack cycle jumps to the pending target.
    always_comb begin
        w_stateNext = r_state;
        w_nPC       = pc;
        w_addrLoad  = 1'b0;
        w_addrNext  = pc;
        w_instLoad  = 1'b0;
        w_validNext = r_instValid;
        w_pendClr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_stateNext = FETCH;
                w_addrLoad  = 1'b1;
            end
            FETCH: begin
                if (imem_ack) begin
                    w_instLoad  = 1'b1;
                    w_validNext = 1'b1;
                    w_stateNext = FULL;
                    w_pendClr   = 1'b1;
                    if (redirect) begin
                        w_nPC = redirect_target;
                    end else if (r_pendValid) begin
                        w_nPC = r_pendTarget;
                    end else begin
                        w_nPC = w_pcInc;
                    end
                end
            end
            FULL: begin
                if (inst_ready) begin
                    w_validNext = 1'b0;
                    w_stateNext = FETCH;
                    w_addrLoad  = 1'b1;
                end
            end
            DRAIN: begin
                w_stateNext = FETCH;
                w_addrLoad  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_pendValid  <= 1'b0;
            r_pendTarget <= '0;
        end else if (w_pendClr) begin
            r_pendValid  <= 1'b0;
        end else if (redirect) begin
            r_pendValid  <= 1'b1;
            r_pendTarget <= redirect_target;
        end
    end
`else
    // A redirect flushes; a request already in flight is drained so its stale data is never delivered.
    always_comb begin
        w_stateNext = r_state;
        w_nPC       = pc;
        w_addrLoad  = 1'b0;
        w_addrNext  = pc;
        w_instLoad  = 1'b0;
        w_validNext = r_instValid;
        case (r_state)
            IDLE: begin
                w_stateNext = FETCH;
                w_addrLoad  = 1'b1;
                if (redirect) begin
                    w_addrNext = redirect_target;
                end
            end
            FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        w_addrLoad = 1'b1;
                        w_addrNext = redirect_target;
                    end else begin
                        w_stateNext = DRAIN;
                    end
                end else if (imem_ack) begin
                    w_instLoad  = 1'b1;
                    w_validNext = 1'b1;
                    w_stateNext = FULL;
                    w_nPC       = w_pcInc;
                end
            end
            FULL: begin
                if (redirect) begin
                    w_stateNext = FETCH;
                    w_addrLoad  = 1'b1;
                    w_addrNext  = redirect_target;
                end else if (inst_ready) begin
                    w_validNext = 1'b0;
                    w_stateNext = FETCH;
                    w_addrLoad  = 1'b1;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_stateNext = FETCH;
                    w_addrLoad  = 1'b1;
                    if (redirect) begin
                        w_addrNext = redirect_target;
                    end
                end
            end
        endcase
        if (redirect) begin
            w_nPC       = redirect_target;
            w_validNext = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_inst      <= '0;
            r_instValid <= 1'b0;
            r_imemAddr  <= '0;
        end else begin
            if (w_instLoad) begin
                r_inst <= imem_rdata;
            end
            r_instValid <= w_validNext;
            if (w_addrLoad) begin
                r_imemAddr <= w_addrNext;
            end
        end
    end

    assign nPC        = Reset ? w_nPC : pc;
    assign imem_req   = (r_state == FETCH) || (r_state == DRAIN);
    assign imem_addr  = r_imemAddr;
    assign inst       = r_inst;
    assign inst_valid = r_instValid;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit (default build): per-cycle vector table through a scoreboard
// queue, plus hand-written reset-abort and fetch-latency sequences.
module tb_ifetch_unit;
    import mips_pkg::*;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] target;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInst;
        logic [31:0] expNpc;
    } vec_t;

    logic        clk;
    logic        Reset;
    logic [31:0] pc;
    logic [31:0] nPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_target;

    int   testsRun  = 0;
    int   failCount = 0;
    vec_t vecs[$];
    vec_t sbQueue[$];

    ifetch_unit #(.ADDR_W(32), .PC_STEP(4)) dut (
        .clk             (clk),
        .Reset           (Reset),
        .pc              (pc),
        .nPC             (nPC),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The PC register lives outside the fetch unit and is loaded from nPC every cycle.
    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= nPC;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addRow(input logic ack, input logic [31:0] rdata, input logic ready,
                                   input logic redir, input logic [31:0] target,
                                   input logic expReq, input logic [31:0] expAddr,
                                   input logic expValid, input logic [31:0] expInst,
                                   input logic [31:0] expNpc);
        vec_t v;
        v.ack = ack;          v.rdata = rdata;       v.ready = ready;
        v.redir = redir;      v.target = target;     v.expReq = expReq;
        v.expAddr = expAddr;  v.expValid = expValid; v.expInst = expInst;
        v.expNpc = expNpc;
        vecs.push_back(v);
    endfunction

    task automatic checkOne(input string what, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %08h expected %08h", what, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        imem_ack        = v.ack;
        imem_rdata      = v.rdata;
        inst_ready      = v.ready;
        redirect        = v.redir;
        redirect_target = v.target;
        sbQueue.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (sbQueue.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL row%0d scoreboard: got empty queue expected an entry", idx);
        end else begin
            e = sbQueue.pop_front();
            checkOne($sformatf("row%0d imem_req", idx),   {31'd0, imem_req},   {31'd0, e.expReq});
            checkOne($sformatf("row%0d imem_addr", idx),  imem_addr,           e.expAddr);
            checkOne($sformatf("row%0d inst_valid", idx), {31'd0, inst_valid}, {31'd0, e.expValid});
            checkOne($sformatf("row%0d inst", idx),       inst,                e.expInst);
            checkOne($sformatf("row%0d nPC", idx),        nPC,                 e.expNpc);
        end
    endtask

    initial begin
        int lat;
        Reset = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_target = '0;

        //      ack rdata         rdy red target         req addr          vld inst          nPC
        addRow(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        addRow(0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        addRow(1, 32'hAAAA0001, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4);
        for (int k = 0; k < 5; k++)
            addRow(0, 32'h0,    0, 0, 32'h0,        0, 32'h0,        1, 32'hAAAA0001, 32'h4);
        addRow(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'hAAAA0001, 32'h4);
        addRow(0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        0, 32'hAAAA0001, 32'h4);
        addRow(1, 32'hBBBB0002, 0, 0, 32'h0,        1, 32'h4,        0, 32'hAAAA0001, 32'h8);
        addRow(0, 32'h0,        1, 0, 32'h0,        0, 32'h4,        1, 32'hBBBB0002, 32'h8);
        addRow(0, 32'h0,        0, 1, 32'h400,      1, 32'h8,        0, 32'hBBBB0002, 32'h400);
        addRow(0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        0, 32'hBBBB0002, 32'h400);
        addRow(1, 32'hDEAD0003, 0, 0, 32'h0,        1, 32'h8,        0, 32'hBBBB0002, 32'h400);
        addRow(0, 32'h0,        0, 0, 32'h0,        1, 32'h400,      0, 32'hBBBB0002, 32'h400);
        addRow(1, 32'hCCCC0004, 0, 1, 32'h800,      1, 32'h400,      0, 32'hBBBB0002, 32'h800);
        addRow(0, 32'h0,        0, 0, 32'h0,        1, 32'h800,      0, 32'hBBBB0002, 32'h800);
        addRow(1, 32'h11110005, 0, 0, 32'h0,        1, 32'h800,      0, 32'hBBBB0002, 32'h804);
        addRow(0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 32'h800,      1, 32'h11110005, 32'hFFFFFFFC);
        addRow(1, 32'h22220006, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h11110005, 32'h0);
        addRow(0, 32'h0,        1, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'h22220006, 32'h0);
        addRow(0, 32'h0,        0, 1, 32'h40,       1, 32'h0,        0, 32'h22220006, 32'h40);
        addRow(0, 32'h0,        0, 1, 32'h80,       1, 32'h0,        0, 32'h22220006, 32'h80);
        addRow(1, 32'h33330007, 0, 0, 32'h0,        1, 32'h0,        0, 32'h22220006, 32'h80);
        addRow(0, 32'h0,        0, 0, 32'h0,        1, 32'h80,       0, 32'h22220006, 32'h80);

        // Held in reset with a redirect asserted: nothing may leak to nPC or the memory port.
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h123;
        #1;
        checkOne("reset imem_req",   {31'd0, imem_req},   32'd0);
        checkOne("reset imem_addr",  imem_addr,           32'h0);
        checkOne("reset inst_valid", {31'd0, inst_valid}, 32'd0);
        checkOne("reset inst",       inst,                32'h0);
        checkOne("reset nPC",        nPC,                 32'h0);
        #2;
        Reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i);
            @(negedge clk);
        end

        // Reset in the middle of an outstanding request abandons it.
        Reset = 1'b0;
        imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        #1;
        checkOne("midreset imem_req",   {31'd0, imem_req},   32'd0);
        checkOne("midreset imem_addr",  imem_addr,           32'h0);
        checkOne("midreset inst",       inst,                32'h0);
        checkOne("midreset nPC",        nPC,                 32'h0);
        @(negedge clk);
        #2;
        Reset = 1'b1;
        #1;
        checkOne("release idle imem_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        #1;
        checkOne("release fetch imem_req",  {31'd0, imem_req}, 32'd1);
        checkOne("release fetch imem_addr", imem_addr,         32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h5555AAAA;
        #1;
        checkOne("release ack nPC", nPC, 32'h4);
        @(negedge clk);
        imem_ack = 1'b0;
        lat = 99;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (inst_valid && lat == 99) lat = c;
            @(negedge clk);
        end
        checkOne("ack to inst_valid latency", lat, 32'd0);
        checkOne("release inst", inst, 32'h5555AAAA);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
